// File: rtl/vsm_accumulator_if.sv
// ----------------------------------------------------------------------------
// vsm_accumulator_if
// Purpose : strobe/ready handshake and result bus between the VSM control
//           sequencer (master) and the 4-bit accumulator stage (slave).
// Signals :
//   Data   [WIDTH-1:0]  operand from the input latch Q output   (master -> slave)
//   Op     [OPW-1:0]    00 NOP, 01 LOAD, 10 ADD, 11 SUB         (master -> slave)
//   Strobe              operation request, sampled while Ready  (master -> slave)
//   Acc    [WIDTH-1:0]  accumulator value                       (slave -> master)
//   Carry               carry (ADD) / borrow (SUB)              (slave -> master)
//   Zero                Acc == 0                                (slave -> master)
//   Ready               accumulator idle, can accept Strobe     (slave -> master)
//   Done                one-cycle completion pulse              (slave -> master)
// ----------------------------------------------------------------------------
interface vsm_accumulator_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned OPW   = 2
);
    logic [WIDTH-1:0] Data;
    logic [OPW-1:0]   Op;
    logic             Strobe;
    logic [WIDTH-1:0] Acc;
    logic             Carry;
    logic             Zero;
    logic             Ready;
    logic             Done;

    // Control sequencer side
    modport master (
        output Data, Op, Strobe,
        input  Acc, Carry, Zero, Ready, Done
    );

    // Accumulator side
    modport slave (
        input  Data, Op, Strobe,
        output Acc, Carry, Zero, Ready, Done
    );
endinterface : vsm_accumulator_if

// File: rtl/vsm_accumulator.sv
// ----------------------------------------------------------------------------
// vsm_accumulator
// Purpose : 4-bit accumulator stage of the VSM datapath. Executes
//           LOAD/ADD/SUB/NOP on a Strobe handshake through a three-state
//           sequence IDLE -> EXEC -> DONE, holding the result and driving the
//           Carry and Zero flags.
// Ports   :
//   Clock   in   single system clock, rising edge active
//   nReset  in   asynchronous, active-low reset
//   bus     slave modport of vsm_accumulator_if (Data, Op, Strobe in;
//           Acc, Carry, Zero, Done registered out; Ready decoded from state)
// Config  :
//   VSM_ACC_SAT_EN  when defined, ADD overflow saturates to all-ones and SUB
//                   underflow clamps to zero (Carry=1 in both cases); when
//                   undefined, ADD/SUB wrap modulo 2^WIDTH.
// ----------------------------------------------------------------------------
module vsm_accumulator #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned OPW   = 2
) (
    input  logic               Clock,
    input  logic               nReset,
    vsm_accumulator_if.slave   bus
);

    localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] OP_LOAD = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] data_q,  data_d;
    logic [OPW-1:0]   op_q,    op_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic             carry_q, carry_d;
    logic             zero_q,  zero_d;
    logic             done_q,  done_d;
    logic             ready_c;

    // Extended-width results; the top bit is the carry-out / borrow
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_c;

    // State register
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and flag registers; reset aborts any op in flight
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            data_q  <= '0;
            op_q    <= OP_NOP;
            acc_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    // Next-state: Strobe only matters in IDLE, it is never queued
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.Strobe) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Arithmetic on the captured operands
    always_comb begin
        sum_c  = {1'b0, acc_q} + {1'b0, data_q};
        diff_c = {1'b0, acc_q} - {1'b0, data_q};
    end

    // Outputs: operand capture on acceptance, result update leaving EXEC
    always_comb begin
        data_d  = data_q;
        op_d    = op_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        ready_c = (state_q == ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.Strobe) begin
                    data_d = bus.Data;
                    op_d   = bus.Op;
                end
            end
            ST_EXEC: begin
                done_d = 1'b1;
                unique case (op_q)
                    OP_LOAD: acc_d = data_q;
                    OP_ADD: begin
`ifdef VSM_ACC_SAT_EN
                        acc_d   = sum_c[WIDTH] ? {WIDTH{1'b1}} : sum_c[WIDTH-1:0];
`else
                        acc_d   = sum_c[WIDTH-1:0];
`endif
                        carry_d = sum_c[WIDTH];
                    end
                    OP_SUB: begin
                        // Borrow out of the extended subtract means Data > Acc
`ifdef VSM_ACC_SAT_EN
                        acc_d   = diff_c[WIDTH] ? '0 : diff_c[WIDTH-1:0];
`else
                        acc_d   = diff_c[WIDTH-1:0];
`endif
                        carry_d = diff_c[WIDTH];
                    end
                    default: acc_d = acc_q;
                endcase
                zero_d = (acc_d == '0);
            end
            ST_DONE: ;
            default: ;
        endcase
    end

    assign bus.Acc   = acc_q;
    assign bus.Carry = carry_q;
    assign bus.Zero  = zero_q;
    assign bus.Done  = done_q;
    assign bus.Ready = ready_c;

endmodule : vsm_accumulator
